// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file writeback arbiter
package regfile_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] RF_ZERO_ADDR = 5'd0;

    // One queued secondary write; kill marks an entry overtaken by a younger
    // primary write to the same register, so its pop must not reach the port.
    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
        logic             kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - secondary writeback FIFO with per-slot visibility and kill marking
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    input  logic [DEPTH-1:0]         kill_set,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH*RF_AW-1:0]   slot_addr,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [DEPTH-1:0]         slot_kill
);

    localparam int IW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy register.
    logic [IW:0]   wptr;
    logic [IW:0]   rptr;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;
    logic [IW-1:0] off;
    wb_entry_t     mem [DEPTH];

    assign widx  = wptr[IW-1:0];
    assign ridx  = rptr[IW-1:0];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[IW] != rptr[IW]) && (widx == ridx);
    assign head  = mem[ridx];

    // Pointer update; the guards keep a misbehaving parent from corrupting state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Entry storage: kill bits are sticky until the slot is rewritten by a push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem[i].kill <= 1'b0;
            end else if (kill_set[i]) begin
                mem[i].kill <= 1'b1;
            end
        end
        if (!rst && push && !full) begin
            mem[widx] <= push_data;
        end
    end

    // Per-slot view: a slot is occupied when its distance from the read
    // index is below the current occupancy.
    always_comb begin
        slot_addr  = '0;
        slot_valid = '0;
        slot_kill  = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off                        = IW'(i) - ridx;
            slot_valid[i]              = ({1'b0, off} < count);
            slot_addr[i*RF_AW +: RF_AW] = mem[i].addr;
            slot_kill[i]               = mem[i].kill;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates primary and queued secondary writes onto the register-file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p_we,
    input  logic [AW-1:0]              p_waddr,
    input  logic [DW-1:0]              p_wdata,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [AW-1:0]              s_waddr,
    input  logic [DW-1:0]              s_wdata,
    output logic                       we,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata,
    output logic [(1<<AW)-1:0]         pend_mask,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    wb_entry_t                   push_data;
    wb_entry_t                   head;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic [$clog2(DEPTH):0]      count;
    logic [DEPTH-1:0]            kill_set;
    logic [DEPTH*RF_AW-1:0]      slot_addr;
    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0]            slot_kill;
    logic                        p_live;

    // Readiness depends only on registered occupancy; a same-cycle pop does
    // not free a slot for this cycle's handshake.
    assign s_ready = !full;
    assign q_count = count;

    // Writes to r0 are architecturally void: accepted but never queued.
    assign push      = s_valid && s_ready && (s_waddr != RF_ZERO_ADDR);
    assign push_data = '{addr: s_waddr, data: s_wdata, kill: 1'b0};

    // The primary source owns the port whenever it asserts p_we, even for r0.
    assign p_live = p_we && (p_waddr != RF_ZERO_ADDR);
    assign pop    = !p_we && !empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .kill_set  (kill_set),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .slot_addr (slot_addr),
        .slot_valid(slot_valid),
        .slot_kill (slot_kill)
    );

    // WAW resolution: a primary write supersedes every older queued write to
    // the same register; an entry pushed at this edge is younger and survives.
    always_comb begin
        kill_set = '0;
        if (p_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (slot_addr[i*RF_AW +: RF_AW] == p_waddr)) begin
                    kill_set[i] = 1'b1;
                end
            end
        end
    end

    // Hazard mask: registers that still have a live queued write in flight.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && !slot_kill[i]) begin
                pend_mask[slot_addr[i*RF_AW +: RF_AW]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Registered write port; address and data hold whenever we is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (p_we) begin
            we <= p_live;
            if (p_live) begin
                waddr <= p_waddr;
                wdata <= p_wdata;
            end
        end else if (!empty) begin
            we <= !head.kill;
            if (!head.kill) begin
                waddr <= head.addr;
                wdata <= head.data;
            end
        end else begin
            we <= 1'b0;
        end
    end

endmodule
